act_share_scheduler: RTL and testbench
======================================

Name: act_share_scheduler

Overview:
- Time-multiplexes one shared pipelined tanh activation unit between NREQ independent requesters.
- Each requester presents IEEE-754 single-precision operands over a valid/ready port. The scheduler grants round-robin, issues one operand per cycle to the unit, and tracks the owner of every in-flight operation in a tag pipeline.
- Results are steered into a per-requester response FIFO.
- Sits between the neuron-layer sequencers and the activation datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 32, operand/result width.
- LATENCY, 4, fixed cycles from act_start sample to act_valid/act_y for that operand.
- RESP_DEPTH, 2, entries per requester response FIFO (power of 2, >=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  requester i has an operand.
- req_data  in  NREQ*DWIDTH  operand of requester i, slice [i*DWIDTH +: DWIDTH].
- req_ready  out  NREQ  operand of requester i accepted this cycle (one-hot or zero).
- resp_valid  out  NREQ  requester i FIFO non-empty.
- resp_data  out  NREQ*DWIDTH  head of FIFO i.
- resp_ready  in  NREQ  requester i pops its FIFO head.
- act_start  out  1  issue strobe to the activation unit.
- act_x  out  DWIDTH  operand to the activation unit.
- act_valid  in  1  result strobe from the activation unit.
- act_y  in  DWIDTH  result from the activation unit.
- busy  out  1  any operation in flight or any FIFO non-empty.
- sync_err  out  1  sticky; act_valid disagreed with the tag pipeline.

Behaviour:
- Reset (async, rst=1): req_ready=0, act_start=0, act_x=0, resp_valid=0, resp_data=0, busy=0, sync_err=0.
  - Tag pipe cleared, FIFOs emptied, round-robin pointer set to 0, all credits set to RESP_DEPTH.
- Credits: credit[i] = RESP_DEPTH - fifo_count[i] - inflight[i], width clog2(RESP_DEPTH+1).
  - Requester i is eligible when req_valid[i]=1 and credit[i]>0.
  - This guarantees a FIFO slot exists for every result, because the unit cannot be stalled.
- Arbitration (combinational from registered state):
  - Grant = first eligible index starting at rr_ptr, wrapping modulo NREQ.
  - req_ready[grant]=1 in the same cycle.
  - On a grant, rr_ptr <= grant+1 (mod NREQ); with no grant, rr_ptr holds.
- Issue is registered. In the cycle after a handshake: act_start=1, act_x=captured operand.
  - Tag pipe stage 0 = {1, grant index}.
  - With no handshake, act_start=0 and act_x holds its previous value.
- Tag pipe:
  - Shift register of depth LATENCY carrying {vld, idx}.
  - Stage LATENCY-1 aligns with act_valid for the matching act_start.
  - Total latency req handshake -> resp_valid is LATENCY+2 cycles (issue register + unit + FIFO write).
- Retire on tag-out vld=1:
  - Push act_y into FIFO[idx] and decrement inflight[idx].
  - If act_valid=0, set sync_err and still push act_y, so credit accounting stays consistent.
  - If act_valid=1 while tag-out vld=0: set sync_err and discard.
- Simultaneous events:
  - Grant and retire for the same i in the same cycle: inflight unchanged.
  - Pop and push on the same FIFO: count unchanged; data stays ordered; a full FIFO is never pushed (credits prevent it).
- Throughput: one issue per cycle sustained when credits allow. A single requester with RESP_DEPTH < LATENCY+2 is throttled by its credits.
- busy = OR(tag vld) | OR(resp_valid) | act_start.
- Reset mid-operation: in-flight tags are dropped. Results arriving after reset are flagged sync_err and discarded, because tag vld=0.

Optional Feature:
- Macro: ACT_SHARE_PERF_EN.
- With the macro:
  - Adds output perf_grants of width NREQ*16, one saturating 16-bit count of handshakes per requester.
  - Adds output perf_stall of width 16, saturating, counting cycles where some req_valid=1 but no grant.
  - Both counters reset to 0 on rst.
- Without the macro: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Package act_share_pkg holds:
  - DWIDTH_DEF=32 and LATENCY_DEF=4.
  - Typedef tag_t as struct {logic vld; logic [2:0] idx;}.
  - Constants FP_POS_ONE=32'h3F800000 and FP_NEG_ONE=32'hBF800000 for benches.
- One sub-module, act_resp_fifo:
  - Parameterised DWIDTH/RESP_DEPTH, instantiated NREQ times.
  - Ports: push, push_data, pop, head, count, empty.

Test Plan:
- Single requester: req0 sends 32'h3E800000 (0.25) -> resp_valid[0] rises exactly LATENCY+2=6 cycles after the handshake, with resp_data[0] equal to the act_y model output; sync_err=0.
- Fairness: all 4 requesters hold req_valid=1, resp_ready=1 -> grants cycle 0,1,2,3,0,... one per cycle; each requester receives 4 of 16 grants.
- Credit backpressure: req1 streams with resp_ready[1]=0, RESP_DEPTH=2 -> exactly 2 handshakes, then req_ready[1]=0 until a pop; one pop produces exactly one further grant.
- Ordering: requesters 2 and 3 interleave 32'h40400000 and 32'hBF000000 -> each FIFO returns its own results in issue order, with no cross-steering.
- Sync fault: model drops act_valid for one issued op -> sync_err=1 and stays high until rst; the credit returns so the requester is not deadlocked.
- Async reset mid-flight: assert rst between clock edges with 3 ops in flight -> all outputs are 0 immediately; after release, the first new request completes normally in 6 cycles.

Source files
------------

// File: rtl/act_share_pkg.sv
// Shared types and constants for the activation-unit share scheduler.
package act_share_pkg;
  localparam int unsigned DWIDTH_DEF  = 32;
  localparam int unsigned LATENCY_DEF = 4;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } tag_t;

  localparam logic [31:0] FP_POS_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
endpackage

// File: rtl/act_share_scheduler_if.sv
// Requester-side operand/response bus of the activation share scheduler.
interface act_share_scheduler_if
  import act_share_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = DWIDTH_DEF
) ();
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [NREQ*DWIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/act_share_scheduler_resp_fifo.sv
// Per-requester response FIFO; head reads as zero while empty.
module act_resp_fifo
  import act_share_pkg::*;
#(
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned RESP_DEPTH = 2,
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1),
  localparam int unsigned AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic [CW-1:0]     count,
  output logic              empty
);
  logic [DWIDTH-1:0] r_mem [RESP_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CW'(RESP_DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/act_share_scheduler.sv
// Round-robin sharing of one pipelined tanh unit among NREQ requesters.
// Optional ACT_SHARE_PERF_EN adds saturating grant/stall counters.
module act_share_scheduler
  import act_share_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  act_share_scheduler_if.slave    bus,
  output logic                    act_start,
  output logic [DWIDTH-1:0]       act_x,
  input  logic                    act_valid,
  input  logic [DWIDTH-1:0]       act_y,
  output logic                    busy,
  output logic                    sync_err
`ifdef ACT_SHARE_PERF_EN
  ,
  output logic [NREQ*16-1:0]      perf_grants,
  output logic [15:0]             perf_stall
`endif
);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0]          r_rr_ptr;
  logic                   r_act_start;
  logic [DWIDTH-1:0]      r_act_x;
  logic [2:0]             r_iss_idx;
  logic                   r_sync_err;
  tag_t                   r_tag [LATENCY];
  logic [CW-1:0]          r_inflight [NREQ];
  logic [CW-1:0]          w_count [NREQ];
  logic [NREQ-1:0]        w_elig;
  logic [NREQ-1:0]        w_empty;
  logic [NREQ-1:0]        w_push;
  logic [NREQ-1:0]        w_pop;
  logic [NREQ*DWIDTH-1:0] w_resp_data;
  logic                   w_gnt_vld;
  logic [PW-1:0]          w_gnt;
  logic                   w_tag_busy;
  tag_t                   w_tag_out;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_elig[i] = bus.req_valid[i] &&
                  ((CW'(RESP_DEPTH) - w_count[i] - r_inflight[i]) != '0);
    end
  end

  always_comb begin
    int unsigned idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'(idx);
      end
    end
    if (rst) w_gnt_vld = 1'b0;
  end

  assign bus.req_ready = w_gnt_vld ? (NREQ'(1) << w_gnt) : '0;
  assign w_tag_out     = r_tag[LATENCY-1];

  // Tag stage 0 is loaded on the edge where the unit samples act_start, so the
  // last stage lines up with act_valid; the issue register is covered by act_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_act_start <= 1'b0;
      r_act_x     <= '0;
      r_iss_idx   <= '0;
      r_sync_err  <= 1'b0;
      for (int unsigned s = 0; s < LATENCY; s++) r_tag[s] <= '0;
    end else begin
      r_act_start <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rr_ptr  <= (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
        r_act_x   <= bus.req_data[32'(w_gnt)*DWIDTH +: DWIDTH];
        r_iss_idx <= 3'(w_gnt);
      end
      r_tag[0] <= '{vld: r_act_start, idx: r_iss_idx};
      for (int unsigned s = 1; s < LATENCY; s++) r_tag[s] <= r_tag[s-1];
      if (act_valid != w_tag_out.vld) r_sync_err <= 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_push[i] = w_tag_out.vld && (w_tag_out.idx == 3'(i));
      w_pop[i]  = bus.resp_ready[i] && !w_empty[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) r_inflight[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_inflight[i] <= r_inflight[i]
                       + CW'(w_gnt_vld && (w_gnt == PW'(i)))
                       - CW'(w_push[i]);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    act_resp_fifo #(
      .DWIDTH     (DWIDTH),
      .RESP_DEPTH (RESP_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push[g]),
      .push_data (act_y),
      .pop       (w_pop[g]),
      .head      (w_resp_data[g*DWIDTH +: DWIDTH]),
      .count     (w_count[g]),
      .empty     (w_empty[g])
    );
  end

  always_comb begin
    w_tag_busy = 1'b0;
    for (int unsigned s = 0; s < LATENCY; s++) w_tag_busy = w_tag_busy | r_tag[s].vld;
  end

  assign bus.resp_valid = ~w_empty;
  assign bus.resp_data  = w_resp_data;
  assign act_start      = r_act_start;
  assign act_x          = r_act_x;
  assign sync_err       = r_sync_err;
  assign busy           = w_tag_busy | (|(~w_empty)) | r_act_start;

`ifdef ACT_SHARE_PERF_EN
  logic [15:0] r_perf_grants [NREQ];
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) r_perf_grants[i] <= '0;
      r_perf_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_gnt_vld && (w_gnt == PW'(i)) && (r_perf_grants[i] != '1))
          r_perf_grants[i] <= r_perf_grants[i] + 16'd1;
      end
      if ((|bus.req_valid) && !w_gnt_vld && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) perf_grants[i*16 +: 16] = r_perf_grants[i];
  end
  assign perf_stall = r_perf_stall;
`endif
endmodule

// File: tb/tb_act_share_scheduler.sv
// Directed self-checking bench for act_share_scheduler with a fixed-latency unit model.
module tb_act_share_scheduler;
  import act_share_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act_start;
  logic [DW-1:0] act_x;
  logic          act_valid;
  logic [DW-1:0] act_y;
  logic          busy;
  logic          sync_err;
`ifdef ACT_SHARE_PERF_EN
  logic [NREQ*16-1:0] perf_grants;
  logic [15:0]        perf_stall;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  act_share_scheduler_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  act_share_scheduler #(
    .NREQ       (NREQ),
    .DWIDTH     (DW),
    .LATENCY    (LAT),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .act_start (act_start),
    .act_x     (act_x),
    .act_valid (act_valid),
    .act_y     (act_y),
    .busy      (busy),
    .sync_err  (sync_err)
`ifdef ACT_SHARE_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Unit model: y = x + 1 after LAT cycles; an FP_NEG_ONE operand loses its strobe.
  logic          m_v [LAT] = '{default: 1'b0};
  logic [DW-1:0] m_d [LAT] = '{default: '0};
  always @(posedge clk) begin
    m_v[0] <= act_start && (act_x != FP_NEG_ONE);
    m_d[0] <= act_x + 32'd1;
    for (int k = 1; k < LAT; k++) begin
      m_v[k] <= m_v[k-1];
      m_d[k] <= m_d[k-1];
    end
  end
  assign act_valid = m_v[LAT-1];
  assign act_y     = m_d[LAT-1];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int unsigned idx, input logic [DW-1:0] d, output logic hs);
    bus.req_data[idx*DW +: DW] = d;
    bus.req_valid[idx]         = 1'b1;
    hs = 1'b0;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready[idx]) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic pop(input int unsigned idx);
    bus.resp_ready[idx] = 1'b1;
    @(negedge clk);
    bus.resp_ready[idx] = 1'b0;
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    n = 0;
    #1;
    while (busy && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({nm, "_drain_busy"}, busy, 1'b0);
    bus.resp_ready = '0;
  endtask

  task automatic lat_check(input int unsigned idx, input logic [DW-1:0] d,
                           input logic [DW-1:0] y, input string nm);
    logic hs;
    int unsigned k;
    send(idx, d, hs);
    check_eq({nm, "_hs"}, hs, 1'b1);
    #1;
    check_eq({nm, "_act_start"}, act_start, 1'b1);
    check_eq({nm, "_act_x"}, act_x, d);
    k = 1;
    while (!bus.resp_valid[idx] && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq({nm, "_latency"}, k, 6);
    check_eq({nm, "_data"}, bus.resp_data[idx*DW +: DW], y);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    logic        hs;
    logic [3:0]  got;
    int unsigned cnt [NREQ];
    int unsigned nhs;
    int          k;

    idle();
    bus.req_valid = '1;
    @(negedge clk); #1;
    check_eq("rst_req_ready",  bus.req_ready, 4'b0000);
    check_eq("rst_act_start",  act_start, 1'b0);
    check_eq("rst_act_x",      act_x, 32'h0);
    check_eq("rst_resp_valid", bus.resp_valid, 4'b0000);
    check_eq("rst_resp_data",  bus.resp_data, 128'h0);
    check_eq("rst_busy",       busy, 1'b0);
    check_eq("rst_sync_err",   sync_err, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Single requester: 0.25 in, latency 6 to the response FIFO.
    lat_check(0, 32'h3E80_0000, 32'h3E80_0001, "single");
    check_eq("single_sync_err", sync_err, 1'b0);
    pop(0);
    check_eq("single_popped", bus.resp_valid[0], 1'b0);
    check_eq("single_idle", busy, 1'b0);

    // Fairness: all requesters valid, one grant per cycle in rotation.
    @(negedge clk);
    do_reset();
    bus.resp_ready = '1;
    bus.req_data   = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    bus.req_valid  = '1;
    #1;
    for (int n = 0; n < 16; n++) begin
      got = bus.req_ready;
      check_eq($sformatf("rr_grant_%0d", n), got, 4'b0001 << (n % 4));
      for (int i = 0; i < NREQ; i++) if (got[i]) cnt[i]++;
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) check_eq($sformatf("rr_count_%0d", i), cnt[i], 4);
    drain("rr");

    // Credit backpressure on requester 1 with its FIFO not being popped.
    @(negedge clk);
    bus.req_data[1*DW +: DW] = 32'h3F00_0000;
    bus.req_valid[1] = 1'b1;
    nhs = 0;
    #1;
    for (int n = 0; n < 12; n++) begin
      if (bus.req_ready[1]) nhs++;
      @(negedge clk); #1;
    end
    check_eq("credit_first_hs", nhs, 2);
    check_eq("credit_blocked", bus.req_ready[1], 1'b0);
    pop(1);
    nhs = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.req_ready[1]) nhs++;
      @(negedge clk); #1;
    end
    check_eq("credit_after_pop_hs", nhs, 1);
    check_eq("credit_head", bus.resp_data[1*DW +: DW], 32'h3F00_0001);
    drain("credit");

    // Ordering: requesters 2 and 3 interleave two values.
    @(negedge clk);
    send(2, 32'h4040_0000, hs); check_eq("ord_hs0", hs, 1'b1);
    send(3, 32'hBF00_0000, hs); check_eq("ord_hs1", hs, 1'b1);
    send(2, 32'hBF00_0000, hs); check_eq("ord_hs2", hs, 1'b1);
    send(3, 32'h4040_0000, hs); check_eq("ord_hs3", hs, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check_eq("ord_r2_first",  bus.resp_data[2*DW +: DW], 32'h4040_0001);
    check_eq("ord_r3_first",  bus.resp_data[3*DW +: DW], 32'hBF00_0001);
    pop(2);
    pop(3);
    check_eq("ord_r2_second", bus.resp_data[2*DW +: DW], 32'hBF00_0001);
    check_eq("ord_r3_second", bus.resp_data[3*DW +: DW], 32'h4040_0001);
    pop(2);
    pop(3);
    check_eq("ord_empty", bus.resp_valid, 4'b0000);
    check_eq("ord_sync_err", sync_err, 1'b0);

    // Sync fault: the unit drops the strobe for one operation.
    @(negedge clk);
    send(0, FP_NEG_ONE, hs);
    check_eq("sync_hs", hs, 1'b1);
    check_eq("sync_err_before", sync_err, 1'b0);
    k = 0;
    #1;
    while (!bus.resp_valid[0] && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("sync_err_set", sync_err, 1'b1);
    check_eq("sync_pushed_data", bus.resp_data[0*DW +: DW], 32'hBF80_0001);
    pop(0);
    send(0, FP_POS_ONE, hs); check_eq("sync_credit_hs0", hs, 1'b1);
    send(0, FP_POS_ONE, hs); check_eq("sync_credit_hs1", hs, 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check_eq("sync_err_sticky", sync_err, 1'b1);
    check_eq("sync_results", bus.resp_valid[0], 1'b1);
    drain("sync");

    // Asynchronous reset between edges with three operations in flight.
    @(negedge clk);
    bus.req_data = {32'h0, 32'h3E00_0000, 32'h3D80_0000, 32'h3D00_0000};
    bus.req_valid = 4'b0111;
    repeat (3) @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_eq("arst_busy_before", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_act_start",  act_start, 1'b0);
    check_eq("arst_act_x",      act_x, 32'h0);
    check_eq("arst_resp_valid", bus.resp_valid, 4'b0000);
    check_eq("arst_resp_data",  bus.resp_data, 128'h0);
    check_eq("arst_busy",       busy, 1'b0);
    check_eq("arst_sync_err",   sync_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("arst_stale_flagged", sync_err, 1'b1);
    check_eq("arst_stale_dropped", bus.resp_valid, 4'b0000);
    check_eq("arst_idle", busy, 1'b0);
    lat_check(2, 32'h3DCC_CCCD, 32'h3DCC_CCCE, "post_rst");
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
